sp_dram_arbiter: RTL and testbench

Round-robin arbiter that shares the single sp_dram user port (we/re command, 25-bit line address, 128-bit data, 16-bit byte mask, ready) between PORTS independent requesters. Sits between the kernel/stream memory clients and sp_dram, in the sp_dram clock domain. Serialises one transaction at a time, returns read data and a per-port ack, and guarantees starvation-free service.

---
 rtl/sp_dram_arbiter.sv | 144 ++++++++++++++
 tb/tb_sp_dram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_dram_arbiter.sv
// sp_dram_arbiter: round-robin arbiter sharing one sp_dram user port between PORTS requesters
// Ports: clk, rst (async active-low);
//        req_we/req_re/req_addr/req_din/req_mask are per-port level requests, held until req_ack;
//        req_ack is a one-hot completion pulse, rd_data is valid with a read ack;
//        grant_id is the port served, busy is high while a transaction is in flight;
//        mem_* drive the sp_dram command interface, mem_dout/mem_ready come back from it.
module sp_dram_arbiter #(
   parameter int PORTS      = 4,
   parameter int ID_WIDTH   = 2,
   parameter int ADDR_WIDTH = 25,
   parameter int DATA_WIDTH = 128,
   parameter int MASK_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS-1:0]            req_we,
   input  logic [PORTS-1:0]            req_re,
   input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [PORTS*DATA_WIDTH-1:0] req_din,
   input  logic [PORTS*MASK_WIDTH-1:0] req_mask,
   output logic [PORTS-1:0]            req_ack,
   output logic [DATA_WIDTH-1:0]       rd_data,
   output logic [ID_WIDTH-1:0]         grant_id,
   output logic                        busy,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]       mem_din,
   output logic [MASK_WIDTH-1:0]       mem_mask,
   output logic                        mem_we,
   output logic                        mem_re,
   input  logic [DATA_WIDTH-1:0]       mem_dout,
   input  logic                        mem_ready
);
   localparam int IW = $clog2(PORTS);
   typedef enum logic [2:0] {IDLE, ISSUE, RD_GAP, RD_WAIT, RD_DONE} state_t;
   state_t                  state_q, state_d;
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, win, idx, gnt_nxt;
   logic                    found;
   logic [PORTS-1:0]        req_any, req_ack_q, req_ack_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d, mem_din_q, mem_din_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [MASK_WIDTH-1:0]   mem_mask_q, mem_mask_d;
   logic                    mem_we_q, mem_we_d, mem_re_q, mem_re_d, busy_q, busy_d;
   logic [ADDR_WIDTH-1:0]   a_arr [PORTS];
   logic [DATA_WIDTH-1:0]   d_arr [PORTS];
   logic [MASK_WIDTH-1:0]   m_arr [PORTS];
   for (genvar g = 0; g < PORTS; g++) begin : g_unpack
      assign a_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign d_arr[g] = req_din[g*DATA_WIDTH +: DATA_WIDTH];
      assign m_arr[g] = req_mask[g*MASK_WIDTH +: MASK_WIDTH];
   end
   // First requesting port at or after rr_ptr, wrapping modulo PORTS.
   always_comb begin
      req_any = req_we | req_re;
      found   = 1'b0;
      win     = '0;
      idx     = '0;
      for (int k = 0; k < PORTS; k++) begin
         idx = IW'((int'(rr_ptr_q) + k) % PORTS);
         if (!found && req_any[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
   assign gnt_nxt = (gnt_q == IW'(PORTS-1)) ? '0 : gnt_q + 1'b1;
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_d      = gnt_q;
      req_ack_d  = '0;
      rd_data_d  = rd_data_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_mask_d = mem_mask_q;
      mem_we_d   = 1'b0;
      mem_re_d   = 1'b0;
      case (state_q)
         IDLE: if (mem_ready && found) begin
            state_d    = ISSUE;
            gnt_d      = win;
            mem_addr_d = a_arr[win];
            mem_din_d  = d_arr[win];
            mem_mask_d = m_arr[win];
            // a port asking for both is served as a write; its read stays pending
            mem_we_d   = req_we[win];
            mem_re_d   = ~req_we[win];
            req_ack_d  = req_we[win] ? PORTS'(1) << win : '0;
         end
         ISSUE: begin
            state_d  = mem_we_q ? IDLE : RD_GAP;
            rr_ptr_d = mem_we_q ? gnt_nxt : rr_ptr_q;
         end
         // sp_dram only drops ready a cycle after re, so ready is not trusted here
         RD_GAP: state_d = RD_WAIT;
         RD_WAIT: if (mem_ready) begin
            state_d   = RD_DONE;
            rd_data_d = mem_dout;
            req_ack_d = PORTS'(1) << gnt_q;
         end
         RD_DONE: begin
            state_d  = IDLE;
            rr_ptr_d = gnt_nxt;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         req_ack_q  <= '0;
         rd_data_q  <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_mask_q <= '0;
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_q      <= gnt_d;
         req_ack_q  <= req_ack_d;
         rd_data_q  <= rd_data_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_mask_q <= mem_mask_d;
         mem_we_q   <= mem_we_d;
         mem_re_q   <= mem_re_d;
         busy_q     <= busy_d;
      end
   end
   assign req_ack  = req_ack_q;
   assign rd_data  = rd_data_q;
   assign grant_id = ID_WIDTH'(gnt_q);
   assign busy     = busy_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_mask = mem_mask_q;
   assign mem_we   = mem_we_q;
   assign mem_re   = mem_re_q;
endmodule

// File: tb/tb_sp_dram_arbiter.sv
// tb_sp_dram_arbiter: directed and randomized checks of sp_dram_arbiter against a transaction-level model
module tb_sp_dram_arbiter;
   localparam int P = 4, AW = 25, DW = 128, MW = 16;
   logic clk = 1'b0, rst;
   logic [P-1:0] req_we, req_re, req_ack;
   logic [P*AW-1:0] req_addr;
   logic [P*DW-1:0] req_din;
   logic [P*MW-1:0] req_mask;
   logic [DW-1:0] rd_data, mem_din, mem_dout;
   logic [1:0] grant_id;
   logic busy, mem_we, mem_re, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [MW-1:0] mem_mask;
   logic [AW-1:0] ta [P];
   logic [DW-1:0] td [P];
   logic [MW-1:0] tm [P];
   for (genvar g = 0; g < P; g++) begin : g_pack
      assign req_addr[g*AW +: AW] = ta[g];
      assign req_din[g*DW +: DW]  = td[g];
      assign req_mask[g*MW +: MW] = tm[g];
   end
   sp_dram_arbiter dut (
      .clk(clk), .rst(rst), .req_we(req_we), .req_re(req_re), .req_addr(req_addr),
      .req_din(req_din), .req_mask(req_mask), .req_ack(req_ack), .rd_data(rd_data),
      .grant_id(grant_id), .busy(busy), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_mask(mem_mask), .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout),
      .mem_ready(mem_ready)
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   int re_pulses = 0, mcnt = 0;
   bit auto_mem = 1'b0;
   logic [AW-1:0] raddr;
   logic [DW-1:0] mem_img [logic [AW-1:0]];
   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      return mem_img.exists(a) ? mem_img[a] : {4{7'h5A, a}};
   endfunction
   function automatic logic [DW-1:0] bytemask(input logic [MW-1:0] m);
      logic [DW-1:0] b;
      b = '0;
      for (int i = 0; i < MW; i++) if (m[4'(i)]) b[i*8 +: 8] = 8'hFF;
      return b;
   endfunction
   // One clock; sample after the edge, run the sp_dram model when enabled.
   task automatic tick();
      @(posedge clk);
      #1;
      if (mem_re === 1'b1) re_pulses++;
      check("we_re_exclusive", {127'd0, mem_we & mem_re}, '0);
      if (auto_mem) begin
         if (mem_re) begin
            mem_ready = 1'b0;
            mcnt = $urandom_range(1, 6);
            raddr = mem_addr;
         end else if (mem_we) begin
            mem_ready = 1'b0;
            mcnt = $urandom_range(1, 2);
         end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               mem_ready = 1'b1;
               mem_dout = memval(raddr);
            end
         end
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   int n, bad, w, j, mptr, age;
   logic [1:0] wi, pw;
   logic [AW-1:0] paddr;
   logic [DW-1:0] last_rd, exp_v, bm;
   bit pend, issue, wr_acked;
   initial begin
      rst = 1'b0;
      req_we = '0;
      req_re = '0;
      for (int i = 0; i < P; i++) begin
         ta[2'(i)] = AW'(i * 16 + 1);
         td[2'(i)] = DW'(i + 100);
         tm[2'(i)] = '1;
      end
      mem_ready = 1'b1;
      mem_dout = '0;
      // reset holds everything at zero even with requests present
      req_we = 4'b1111;
      repeat (3) tick();
      check("rst_ack", req_ack, '0);
      check("rst_we", mem_we, '0);
      check("rst_re", mem_re, '0);
      check("rst_busy", busy, '0);
      check("rst_grant", grant_id, '0);
      check("rst_rd_data", rd_data, '0);
      check("rst_addr", mem_addr, '0);
      check("rst_din", mem_din, '0);
      check("rst_mask", mem_mask, '0);
      rst = 1'b1;
      tick();
      check("first_we", mem_we, 1);
      check("first_grant", grant_id, 0);
      check("first_ack", req_ack, 4'b0001);
      check("first_addr", mem_addr, ta[0]);
      // fairness: all ports hold write requests
      for (int k = 1; k < 8; k++) begin
         n = 0;
         do begin tick(); n++; end while (req_ack === '0 && n < 10);
         check($sformatf("fair_ack%0d", k), req_ack, 4'(1) << (k % 4));
      end
      req_we = '0;
      tick();
      // single read on port 2 with a slow DRAM
      ta[2] = 25'h0000ABC;
      req_re[2] = 1'b1;
      re_pulses = 0;
      n = 0;
      while (mem_re !== 1'b1 && n < 8) begin tick(); n++; end
      check("rd_issue", mem_re, 1);
      check("rd_addr", mem_addr, 25'h0000ABC);
      check("rd_grant", grant_id, 2);
      mem_ready = 1'b0;
      repeat (5) tick();
      mem_dout = 128'hDEADBEEF;
      mem_ready = 1'b1;
      n = 0;
      while (req_ack === '0 && n < 10) begin tick(); n++; end
      check("rd_ack", req_ack, 4'b0100);
      check("rd_data", rd_data, 128'hDEADBEEF);
      req_re[2] = 1'b0;
      tick();
      check("rd_busy_after", busy, 0);
      check("rd_single_pulse", re_pulses, 1);
      // back-pressure: no grant while ready is low
      mem_ready = 1'b0;
      req_we[1] = 1'b1;
      ta[1] = 25'h1F0;
      bad = 0;
      repeat (20) begin
         tick();
         if (mem_we || mem_re || busy) bad++;
      end
      check("bp_idle", bad, 0);
      mem_ready = 1'b1;
      tick();
      check("bp_we", mem_we, 1);
      check("bp_ack", req_ack, 4'b0010);
      req_we[1] = 1'b0;
      tick();
      // simultaneous write and read on port 3: write first
      ta[3] = 25'h123;
      td[3] = 128'h1;
      tm[3] = 16'h00FF;
      mem_dout = 128'h55;
      req_we[3] = 1'b1;
      req_re[3] = 1'b1;
      tick();
      check("wr_first_we", mem_we, 1);
      check("wr_first_re", mem_re, 0);
      check("wr_first_mask", mem_mask, 16'h00FF);
      check("wr_first_din", mem_din, 128'h1);
      check("wr_first_ack", req_ack, 4'b1000);
      req_we[3] = 1'b0;
      n = 0;
      while (mem_re !== 1'b1 && n < 6) begin tick(); n++; end
      check("then_rd_issue", mem_re, 1);
      check("then_rd_grant", grant_id, 3);
      n = 0;
      while (req_ack === '0 && n < 10) begin tick(); n++; end
      check("then_rd_ack", req_ack, 4'b1000);
      check("then_rd_data", rd_data, 128'h55);
      req_re[3] = 1'b0;
      tick();
      // move the pointer to 3, then abandon a read from port 3 with reset
      req_we[2] = 1'b1;
      tick();
      check("pre_ack", req_ack, 4'b0100);
      req_we[2] = 1'b0;
      tick();
      ta[3] = 25'h77;
      req_re[3] = 1'b1;
      n = 0;
      while (mem_re !== 1'b1 && n < 6) begin tick(); n++; end
      check("rr_rd_grant", grant_id, 3);
      mem_ready = 1'b0;
      tick();
      tick();
      check("rr_busy_wait", busy, 1);
      rst = 1'b0;
      #1;
      check("rr_ack", req_ack, '0);
      check("rr_busy", busy, 0);
      check("rr_data", rd_data, '0);
      req_re[3] = 1'b0;
      bad = 0;
      repeat (2) begin tick(); if (req_ack !== '0) bad++; end
      req_we[1] = 1'b1;
      req_we[3] = 1'b1;
      rst = 1'b1;
      repeat (3) begin tick(); if (req_ack !== '0 || busy !== 1'b0) bad++; end
      check("rr_wait_ready", bad, 0);
      mem_ready = 1'b1;
      tick();
      check("rr_ptr0_ack", req_ack, 4'b0010);
      req_we[1] = 1'b0;
      n = 0;
      do begin tick(); n++; end while (req_ack === '0 && n < 6);
      check("rr_next_ack", req_ack, 4'b1000);
      req_we[3] = 1'b0;
      // randomized traffic against the transaction-level model
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mem_ready = 1'b1;
      mptr = 0;
      last_rd = '0;
      pend = 1'b0;
      age = 0;
      auto_mem = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         issue = mem_we | mem_re;
         wr_acked = 1'b0;
         if (issue) begin
            check("one_outstanding", {127'd0, pend}, '0);
            w = -1;
            for (int k = 0; k < P; k++) begin
               j = (mptr + k) % P;
               if (w < 0 && (req_we[2'(j)] || req_re[2'(j)])) w = j;
            end
            check("issue_has_req", {127'd0, w >= 0}, 1);
            if (w >= 0) begin
               wi = 2'(w);
               check("r_grant", grant_id, wi);
               check("r_addr", mem_addr, ta[wi]);
               check("r_is_write", mem_we, req_we[wi]);
               if (req_we[wi]) begin
                  check("r_din", mem_din, td[wi]);
                  check("r_mask", mem_mask, tm[wi]);
                  check("r_wr_ack", req_ack, 4'(1) << wi);
                  check("r_rd_hold", rd_data, last_rd);
                  bm = bytemask(tm[wi]);
                  mem_img[ta[wi]] = (memval(ta[wi]) & ~bm) | (td[wi] & bm);
                  mptr = (w + 1) % P;
                  req_we[wi] = 1'b0;
                  wr_acked = 1'b1;
               end else begin
                  pend = 1'b1;
                  pw = wi;
                  paddr = ta[wi];
                  age = 0;
               end
            end
         end
         if (!wr_acked) begin
            if (req_ack !== '0) begin
               if (pend && !issue) begin
                  check("r_rd_ack", req_ack, 4'(1) << pw);
                  exp_v = memval(paddr);
                  check("r_rd_data", rd_data, exp_v);
                  last_rd = exp_v;
                  pend = 1'b0;
                  req_re[pw] = 1'b0;
                  mptr = (int'(pw) + 1) % P;
               end else check("unexpected_ack", req_ack, '0);
            end
            if (pend) begin
               age++;
               if (age > 40) begin
                  check("rd_timeout", age, 0);
                  pend = 1'b0;
               end
            end
         end
         if (cyc < 2800) begin
            for (int k = 0; k < P; k++) begin
               if (!req_we[2'(k)] && !req_re[2'(k)] && $urandom_range(0, 3) == 0) begin
                  n = $urandom_range(0, 2);
                  req_we[2'(k)] = n != 1;
                  req_re[2'(k)] = n != 0;
                  ta[2'(k)] = AW'($urandom_range(0, 7));
                  td[2'(k)] = {$urandom, $urandom, $urandom, $urandom};
                  tm[2'(k)] = MW'($urandom);
               end
            end
         end
      end
      check("drained", {123'd0, pend, req_we | req_re}, '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
